// File: rtl/rv32i_csr_pkg.sv
// rtl/rv32i_csr_pkg.sv - machine-mode CSR addresses, trap cause codes and trap sequencer states
package rv32i_csr_pkg;

    localparam logic [11:0] MTVEC  = 12'h305;
    localparam logic [11:0] MEPC   = 12'h341;
    localparam logic [11:0] MCAUSE = 12'h342;
    localparam logic [11:0] MTVAL  = 12'h343;

    localparam logic [3:0] CAUSE_IAF   = 4'd1;
    localparam logic [3:0] CAUSE_ILL   = 4'd2;
    localparam logic [3:0] CAUSE_LOAD  = 4'd5;
    localparam logic [3:0] CAUSE_STORE = 4'd7;

    // mtval source select produced by the cause encoder
    localparam logic [1:0] TVAL_PC    = 2'd0;
    localparam logic [1:0] TVAL_INSTR = 2'd1;
    localparam logic [1:0] TVAL_ADDR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAVE_EPC   = 3'd1,
        ST_SAVE_CAUSE = 3'd2,
        ST_SAVE_TVAL  = 3'd3,
        ST_RD_TVEC    = 3'd4,
        ST_RD_EPC     = 3'd5,
        ST_REDIRECT   = 3'd6
    } trap_state_e;

endpackage

// File: rtl/trap_cause_enc.sv
// rtl/trap_cause_enc.sv - priority encoder from exception flags to cause code and mtval source
// Ports: exc_iaf/exc_ill/exc_daf/exc_store in; exc_any, cause[3:0], tval_sel[1:0] out.
module trap_cause_enc
    import rv32i_csr_pkg::*;
(
    input  logic       exc_iaf,
    input  logic       exc_ill,
    input  logic       exc_daf,
    input  logic       exc_store,
    output logic       exc_any,
    output logic [3:0] cause,
    output logic [1:0] tval_sel
);

    always_comb begin
        exc_any  = exc_iaf | exc_ill | exc_daf;
        cause    = 4'd0;
        tval_sel = TVAL_PC;
        if (exc_iaf) begin
            cause    = CAUSE_IAF;
            tval_sel = TVAL_PC;
        end else if (exc_ill) begin
            cause    = CAUSE_ILL;
            tval_sel = TVAL_INSTR;
        end else if (exc_daf) begin
            cause    = exc_store ? CAUSE_STORE : CAUSE_LOAD;
            tval_sel = TVAL_ADDR;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer driving the CSR write port and PC redirect
// Ports: clk, rst_n; exc_iaf/exc_ill/exc_daf/exc_store, mret, instr, pc, ram_addr, csr_rd in;
//        stall, flush, csr_w, csr_addr, csr_wd, redirect, redirect_pc out.
module trap_ctrl #(
    parameter int XLEN   = 32,
    parameter int RAM_AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_iaf,
    input  logic              exc_ill,
    input  logic              exc_daf,
    input  logic              exc_store,
    input  logic              mret,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   pc,
    input  logic [RAM_AW-1:0] ram_addr,
    input  logic [XLEN-1:0]   csr_rd,
    output logic              stall,
    output logic              flush,
    output logic              csr_w,
    output logic [11:0]       csr_addr,
    output logic [XLEN-1:0]   csr_wd,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc
);
    import rv32i_csr_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    trap_state_e     state_q, state_d;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] target_q, target_d;

    logic       exc_any;
    logic [3:0] enc_cause;
    logic [1:0] enc_tval_sel;

    trap_cause_enc u_enc (
        .exc_iaf  (exc_iaf),
        .exc_ill  (exc_ill),
        .exc_daf  (exc_daf),
        .exc_store(exc_store),
        .exc_any  (exc_any),
        .cause    (enc_cause),
        .tval_sel (enc_tval_sel)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        target_d    = target_q;
        stall       = 1'b1;
        flush       = 1'b0;
        csr_w       = 1'b0;
        csr_addr    = 12'h000;
        csr_wd      = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        case (state_q)
            ST_IDLE: begin
                // Only the exception path stalls in IDLE; mret retires normally this cycle.
                stall = exc_any;
                flush = exc_any;
                if (exc_any) begin
                    cause_d = enc_cause;
                    epc_d   = pc & ALIGN_MASK;
                    case (enc_tval_sel)
                        TVAL_PC:    tval_d = pc;
                        TVAL_INSTR: tval_d = XLEN'(instr);
                        TVAL_ADDR:  tval_d = XLEN'(ram_addr);
                        default:    tval_d = '0;
                    endcase
                    state_d = ST_SAVE_EPC;
                end else if (mret) begin
                    state_d = ST_RD_EPC;
                end
            end
            ST_SAVE_EPC: begin
                csr_w    = 1'b1;
                csr_addr = MEPC;
                csr_wd   = epc_q;
                state_d  = ST_SAVE_CAUSE;
            end
            ST_SAVE_CAUSE: begin
                csr_w    = 1'b1;
                csr_addr = MCAUSE;
                csr_wd   = XLEN'(cause_q);
                state_d  = ST_SAVE_TVAL;
            end
            ST_SAVE_TVAL: begin
                csr_w    = 1'b1;
                csr_addr = MTVAL;
                csr_wd   = tval_q;
                state_d  = ST_RD_TVEC;
            end
            ST_RD_TVEC: begin
                // Direct mode only: the low mode bits of mtvec are dropped.
                csr_addr = MTVEC;
                target_d = csr_rd & ALIGN_MASK;
                state_d  = ST_REDIRECT;
            end
            ST_RD_EPC: begin
                csr_addr = MEPC;
                target_d = csr_rd & ALIGN_MASK;
                state_d  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect    = 1'b1;
                redirect_pc = target_q;
                state_d     = ST_IDLE;
            end
            default: begin
                stall   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl with a small CSR file model
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_iaf, exc_ill, exc_daf, exc_store, mret;
    logic [31:0] instr, pc;
    logic [15:0] ram_addr;
    logic [31:0] csr_rd;
    logic        stall, flush, csr_w, redirect;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd, redirect_pc;

    // CSR file model
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        tb_wr;
    logic [11:0] tb_waddr;
    logic [31:0] tb_wd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.XLEN(32), .RAM_AW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exc_iaf    (exc_iaf),
        .exc_ill    (exc_ill),
        .exc_daf    (exc_daf),
        .exc_store  (exc_store),
        .mret       (mret),
        .instr      (instr),
        .pc         (pc),
        .ram_addr   (ram_addr),
        .csr_rd     (csr_rd),
        .stall      (stall),
        .flush      (flush),
        .csr_w      (csr_w),
        .csr_addr   (csr_addr),
        .csr_wd     (csr_wd),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always_comb begin
        csr_rd = 32'h0;
        case (csr_addr)
            12'h305: csr_rd = m_mtvec;
            12'h341: csr_rd = m_mepc;
            12'h342: csr_rd = m_mcause;
            12'h343: csr_rd = m_mtval;
            default: csr_rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (csr_w) begin
            case (csr_addr)
                12'h305: m_mtvec  <= csr_wd;
                12'h341: m_mepc   <= csr_wd;
                12'h342: m_mcause <= csr_wd;
                12'h343: m_mtval  <= csr_wd;
                default: ;
            endcase
        end else if (tb_wr) begin
            case (tb_waddr)
                12'h305: m_mtvec  <= tb_wd;
                12'h341: m_mepc   <= tb_wd;
                12'h342: m_mcause <= tb_wd;
                12'h343: m_mtval  <= tb_wd;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_flush"}, 32'(flush), 0);
        chk({tag, "_csr_w"}, 32'(csr_w), 0);
        chk({tag, "_csr_addr"}, 32'(csr_addr), 0);
        chk({tag, "_csr_wd"}, csr_wd, 0);
        chk({tag, "_redirect"}, 32'(redirect), 0);
        chk({tag, "_redirect_pc"}, redirect_pc, 0);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the cycle after REDIRECT.
    task automatic do_trap(input logic iaf, input logic ill, input logic daf, input logic st,
                           input logic mr, input logic [31:0] ins, input logic [31:0] p,
                           input logic [15:0] ra, input logic [31:0] e_epc,
                           input logic [31:0] e_cause, input logic [31:0] e_tval,
                           input logic [31:0] e_target);
        exc_iaf = iaf; exc_ill = ill; exc_daf = daf; exc_store = st; mret = mr;
        instr = ins; pc = p; ram_addr = ra;
        #1;
        chk("det_stall", 32'(stall), 1);
        chk("det_flush", 32'(flush), 1);
        chk("det_csr_w", 32'(csr_w), 0);
        @(negedge clk);
        exc_iaf = 0; exc_ill = 0; exc_daf = 0; exc_store = 0; mret = 0;
        chk("epc_w", 32'(csr_w), 1);
        chk("epc_addr", 32'(csr_addr), 32'h341);
        chk("epc_wd", csr_wd, e_epc);
        chk("epc_stall", 32'(stall), 1);
        chk("epc_flush", 32'(flush), 0);
        @(negedge clk);
        chk("cause_w", 32'(csr_w), 1);
        chk("cause_addr", 32'(csr_addr), 32'h342);
        chk("cause_wd", csr_wd, e_cause);
        chk("cause_stall", 32'(stall), 1);
        @(negedge clk);
        chk("tval_w", 32'(csr_w), 1);
        chk("tval_addr", 32'(csr_addr), 32'h343);
        chk("tval_wd", csr_wd, e_tval);
        chk("tval_stall", 32'(stall), 1);
        @(negedge clk);
        chk("tvec_w", 32'(csr_w), 0);
        chk("tvec_addr", 32'(csr_addr), 32'h305);
        chk("tvec_stall", 32'(stall), 1);
        chk("tvec_redirect", 32'(redirect), 0);
        @(negedge clk);
        chk("redir", 32'(redirect), 1);
        chk("redir_pc", redirect_pc, e_target);
        chk("redir_stall", 32'(stall), 1);
        chk("redir_csr_w", 32'(csr_w), 0);
        @(negedge clk);
        chk("post_stall", 32'(stall), 0);
        chk("post_redirect", 32'(redirect), 0);
        chk("model_mepc", m_mepc, e_epc);
        chk("model_mcause", m_mcause, e_cause);
        chk("model_mtval", m_mtval, e_tval);
    endtask

    initial begin
        rst_n = 0;
        exc_iaf = 0; exc_ill = 0; exc_daf = 0; exc_store = 0; mret = 0;
        instr = 0; pc = 0; ram_addr = 0;
        tb_wr = 0; tb_waddr = 0; tb_wd = 0;
        m_mtvec = 32'h100; m_mepc = 0; m_mcause = 0; m_mtval = 0;

        @(negedge clk);
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        rst_n = 1;
        #1;
        chk_idle_zero("idle");

        // Illegal instruction, then a store fault in the very next IDLE cycle.
        do_trap(0, 1, 0, 0, 0, 32'h0000207F, 32'd24, 16'd0,
                32'd24, 32'd2, 32'h0000207F, 32'h100);
        do_trap(0, 0, 1, 1, 0, 32'h0, 32'd32, 16'd76,
                32'd32, 32'd7, 32'd76, 32'h100);
        // iaf beats ill, and the exception wins over a simultaneous mret.
        do_trap(1, 1, 0, 0, 1, 32'hDEADBEEF, 32'd112, 16'd0,
                32'd112, 32'd1, 32'd112, 32'h100);

        // mret: mepc preloaded to 0x1C.
        tb_wr = 1; tb_waddr = 12'h341; tb_wd = 32'h1C;
        @(negedge clk);
        tb_wr = 0;
        mret = 1;
        #1;
        chk("mret_det_stall", 32'(stall), 0);
        chk("mret_det_flush", 32'(flush), 0);
        @(negedge clk);
        mret = 0;
        chk("mret_rd_addr", 32'(csr_addr), 32'h341);
        chk("mret_rd_w", 32'(csr_w), 0);
        chk("mret_rd_stall", 32'(stall), 1);
        @(negedge clk);
        chk("mret_redir", 32'(redirect), 1);
        chk("mret_redir_pc", redirect_pc, 32'h1C);
        chk("mret_redir_w", 32'(csr_w), 0);
        @(negedge clk);
        chk("mret_post_stall", 32'(stall), 0);
        chk("mret_mcause_kept", m_mcause, 32'd1);

        // Reset pulsed during SAVE_CAUSE of a load fault at an unaligned pc.
        exc_daf = 1; exc_store = 0; pc = 32'h46; ram_addr = 16'hFFFF;
        @(negedge clk);
        exc_daf = 0;
        chk("rst_seq_epc_addr", 32'(csr_addr), 32'h341);
        chk("rst_seq_epc_wd", csr_wd, 32'h44);
        @(negedge clk);
        chk("rst_seq_cause_addr", 32'(csr_addr), 32'h342);
        rst_n = 0;
        #1;
        chk_idle_zero("midrst");
        @(negedge clk);
        chk_idle_zero("midrst_hold");
        rst_n = 1;
        @(negedge clk);
        chk_idle_zero("after_rst");
        chk("partial_mepc", m_mepc, 32'h44);
        chk("partial_mcause", m_mcause, 32'd1);
        chk("partial_mtval", m_mtval, 32'd112);

        do_trap(0, 0, 1, 0, 0, 32'h0, 32'h46, 16'hFFFF,
                32'h44, 32'd5, 32'h0000FFFF, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer feeding the CSR file's single write port (`csr_w`/`csr`/`wd`) and reading back through `rd`. On a synchronous exception it stalls the core, writes `mepc`, `mcause` and `mtval` over successive cycles, reads `mtvec`, and issues a one-cycle PC redirect. On `mret` it reads `mepc` and redirects. It sits between the exception-detect logic and the CSR file on one side, and the fetch/PC mux on the other.

## Interface
Parameters:
- `XLEN`, 32, data and PC width.
- `RAM_AW`, 16, data-address width; zero-extended to XLEN for `mtval`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `exc_iaf`  in  1  instruction access fault (bad ROM address).
- `exc_ill`  in  1  illegal opcode.
- `exc_daf`  in  1  data access fault (bad RAM address).
- `exc_store`  in  1  qualifies `exc_daf`: 1 = store, 0 = load.
- `mret`  in  1  `mret` retiring this cycle.
- `instr`  in  32  faulting instruction word.
- `pc`  in  XLEN  PC of the faulting or `mret` instruction.
- `ram_addr`  in  RAM_AW  faulting data address.
- `csr_rd`  in  XLEN  combinational read data from the CSR file.
- `stall`  out  1  freezes PC and pipeline registers.
- `flush`  out  1  kills the faulting instruction's writeback/memory write.
- `csr_w`  out  1  CSR write enable.
- `csr_addr`  out  12  CSR address (write and read).
- `csr_wd`  out  XLEN  CSR write data.
- `redirect`  out  1  one-cycle PC load strobe.
- `redirect_pc`  out  XLEN  new PC, valid with `redirect`.

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, RD_TVEC, RD_EPC, REDIRECT.
- IDLE, any `exc_*` high: latch cause, `mtval`, and `{pc[XLEN-1:2],2'b00}`, then go to SAVE_EPC. In the same cycle, `stall`=1 and `flush`=1 combinationally.
- IDLE, `mret` with no exception: latch nothing, then go to RD_EPC. Exception wins over a simultaneous `mret`.
- Priority: `exc_iaf` > `exc_ill` > `exc_daf`.
- Cause codes: iaf=1, ill=2, load fault=5, store fault=7.
- `mtval` value:
  - iaf: `pc`.
  - ill: `instr`.
  - daf: zero-extended `ram_addr`.
- SAVE_EPC: `csr_w`=1, `csr_addr`=0x341, `csr_wd`=latched EPC.
- SAVE_CAUSE: `csr_w`=1, `csr_addr`=0x342, `csr_wd`=cause (bit 31 = 0).
- SAVE_TVAL: `csr_w`=1, `csr_addr`=0x343, `csr_wd`=latched `mtval`.
- RD_TVEC: `csr_addr`=0x305, `csr_w`=0; register `{csr_rd[XLEN-1:2],2'b00}` as the target (direct mode only).
- RD_EPC: `csr_addr`=0x341, `csr_w`=0; register `{csr_rd[XLEN-1:2],2'b00}` as the target.
- REDIRECT: `redirect`=1, `redirect_pc`=target; return to IDLE.
- `stall`=1 in every non-IDLE state. `flush`=1 only in the IDLE detect cycle.
- All `exc_*` and `mret` inputs are ignored outside IDLE; no nesting.
- Outputs are Moore from state and registers, except `stall`/`flush` in IDLE (Mealy on the `exc_*` inputs).
- Reset values: state IDLE. `stall`, `flush`, `csr_w`, `redirect` = 0. `csr_addr`=0, `csr_wd`=0, `redirect_pc`=0. All latches cleared.

## Timing
- Exception detected in cycle N. CSR writes in N+1, N+2, N+3 (write commits at the end of each cycle). `mtvec` read in N+4. `redirect` in N+5. First handler fetch in N+6.
- `mret` in cycle N: `mepc` read in N+1, `redirect` in N+2.
- `csr_rd` must be combinational from `csr_addr` with the same-cycle CSR value. The `mtvec` read in N+4 sees all prior writes.
- `stall` is high continuously from N (exception) through the REDIRECT cycle, and drops in the cycle after.
- `rst_n` low at any point, including mid-sequence: immediate return to IDLE, all outputs at reset values. A partially written trap record is left as-is.
- Back-to-back: an exception present in the cycle right after REDIRECT is accepted normally.

## Structure
- Shared package `rv32i_csr_pkg` holds:
  - CSR address constants: `MTVEC`=0x305, `MEPC`=0x341, `MCAUSE`=0x342, `MTVAL`=0x343.
  - Cause code constants.
  - The trap state enum.
- One combinational sub-module, `trap_cause_enc`: priority encoder from `exc_*`/`exc_store` to a 4-bit cause plus a 2-bit `mtval` source select.

## Test plan
- `exc_ill`, `instr`=0x0000207F, `pc`=24, `mtvec` preloaded 0x100:
  - N+1..N+3 write 0x341←24, 0x342←2, 0x343←0x0000207F.
  - N+5 `redirect` with `redirect_pc`=0x100.
  - `stall` high for 6 cycles.
- `exc_daf` with `exc_store`=1, `ram_addr`=76, `pc`=32 → `mcause`←7, `mtval`←76, `mepc`←32.
- `exc_iaf` and `exc_ill` together, `pc`=112 → `mcause`←1, `mtval`←112.
- `mret` with `mepc`=0x1C → N+1 `csr_addr`=0x341, no writes; N+2 `redirect_pc`=0x1C.
- `rst_n` pulsed low during SAVE_CAUSE → all outputs 0 that cycle, no further writes. A new exception after release restarts at SAVE_EPC.
